// File: rtl/status_banner_if.sv
// Banner handshake and HUD bus between the game-state sequencer (master)
// and the status_banner controller (slave).
interface status_banner_if;
  logic        enable;
  logic [2:0]  game_status;
  logic [1:0]  world;
  logic [2:0]  level;
  logic [3:0]  lives;
  logic        end_time;
  logic        busy;
  logic [3:0]  msg_code;
  logic [15:0] digits;
  logic        blank;

  modport master (
    output enable, game_status, world, level, lives,
    input  end_time, busy, msg_code, digits, blank
  );

  modport slave (
    input  enable, game_status, world, level, lives,
    output end_time, busy, msg_code, digits, blank
  );
endinterface

// File: rtl/status_banner.sv
// Timed banner / HUD controller. In IDLE the display tracks the live game
// status; on a request the status is frozen and shown as a blinking banner
// for BANNER_CYCLES cycles, after which end_time is held until the request
// drops. Dropping the request before the banner completes aborts it.
module status_banner #(
  parameter int unsigned BANNER_CYCLES = 100_000_000,
  parameter int unsigned BLINK_CYCLES  = 25_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic           clk,
  input  logic           reset,
  status_banner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_CYCLES - 32'd1);

  // Status 7 is not a real game state; the display driver shows it as blank.
  function automatic logic [3:0] msg_of(input logic [2:0] st);
    logic [3:0] m;
    if (st == 3'd7) begin
      m = 4'hF;
    end else begin
      m = {1'b0, st};
    end
    return m;
  endfunction

  // Convert 0-based world/level to 1-based digits, clamp lives to one digit.
  function automatic logic [15:0] digits_of(input logic [1:0] w,
                                            input logic [2:0] l,
                                            input logic [3:0] lv);
    logic [3:0] lv_sat;
    logic [3:0] w_dig;
    logic [3:0] l_dig;
    if (lv > 4'd9) begin
      lv_sat = 4'd9;
    end else begin
      lv_sat = lv;
    end
    w_dig = {2'b00, w} + 4'd1;
    l_dig = {1'b0, l} + 4'd1;
    return {w_dig, l_dig, lv_sat, 4'hF};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic [2:0]       snap_status_q, snap_status_d;
  logic [1:0]       snap_world_q, snap_world_d;
  logic [2:0]       snap_level_q, snap_level_d;
  logic [3:0]       snap_lives_q, snap_lives_d;
  logic             end_time_q, end_time_d;
  logic             blank_q, blank_d;
  logic [3:0]       msg_code_q, msg_code_d;
  logic [15:0]      digits_q, digits_d;

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dur_q         <= '0;
      blink_q       <= '0;
      snap_status_q <= 3'd0;
      snap_world_q  <= 2'd0;
      snap_level_q  <= 3'd0;
      snap_lives_q  <= 4'd0;
      end_time_q    <= 1'b0;
      blank_q       <= 1'b0;
      msg_code_q    <= 4'd0;
      digits_q      <= 16'h0000;
    end else begin
      state_q       <= state_d;
      dur_q         <= dur_d;
      blink_q       <= blink_d;
      snap_status_q <= snap_status_d;
      snap_world_q  <= snap_world_d;
      snap_level_q  <= snap_level_d;
      snap_lives_q  <= snap_lives_d;
      end_time_q    <= end_time_d;
      blank_q       <= blank_d;
      msg_code_q    <= msg_code_d;
      digits_q      <= digits_d;
    end
  end

  // Next state, counter updates and next output values.
  always_comb begin
    state_d       = state_q;
    dur_d         = dur_q;
    blink_d       = blink_q;
    snap_status_d = snap_status_q;
    snap_world_d  = snap_world_q;
    snap_level_d  = snap_level_q;
    snap_lives_d  = snap_lives_q;
    end_time_d    = 1'b0;
    blank_d       = 1'b0;
    msg_code_d    = msg_of(snap_status_q);
    digits_d      = digits_of(snap_world_q, snap_level_q, snap_lives_q);

    case (state_q)
      IDLE: begin
        // Live HUD; on the request edge the live values equal the snapshot.
        msg_code_d = msg_of(bus.game_status);
        digits_d   = digits_of(bus.world, bus.level, bus.lives);
        dur_d      = '0;
        blink_d    = '0;
        if (bus.enable) begin
          snap_status_d = bus.game_status;
          snap_world_d  = bus.world;
          snap_level_d  = bus.level;
          snap_lives_d  = bus.lives;
          state_d       = SHOW;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (!bus.enable) begin
          // Abort wins over reaching the terminal count on the same edge.
          state_d = IDLE;
        end else if (dur_q == BANNER_LAST) begin
          state_d    = DONE;
          end_time_d = 1'b1;
        end else begin
          dur_d = dur_q + 1'b1;
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            blank_d = ~blank_q;
          end else begin
            blink_d = blink_q + 1'b1;
            blank_d = blank_q;
          end
        end
      end
      DONE: begin
        if (bus.enable) begin
          end_time_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.end_time = end_time_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.blank    = blank_q;
  assign bus.msg_code = msg_code_q;
  assign bus.digits   = digits_q;

endmodule
